// File: rtl/piso_serializer.sv
// Parallel-in/serial-out shifter with valid/ready load and back-to-back words.
// Optional trailing even-parity bit is enabled with the PISO_PARITY_EN macro.
module piso_serializer #(
  parameter int WIDTH     = 4,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] x,
  input  logic             load_valid,
  output logic             load_ready,
  output logic             sout,
  output logic             sout_valid,
  output logic             done
);

  localparam int CNT_W = $clog2(WIDTH + 1);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH);

`ifdef PISO_PARITY_EN
  typedef enum logic [1:0] {IDLE, SHIFT, PARITY} state_t;
  localparam bit DONE_ON_DATA = 1'b0;
`else
  typedef enum logic [0:0] {IDLE, SHIFT} state_t;
  localparam bit DONE_ON_DATA = 1'b1;
`endif

  state_t           r_state;
  logic [CNT_W-1:0] r_cnt;
  logic [WIDTH-1:0] r_shift;
  logic             r_sout;
  logic             r_valid;
  logic             r_done;

  state_t           w_nextState;
  logic [CNT_W-1:0] w_nextCnt;
  logic [CNT_W-1:0] w_cntInc;
  logic [WIDTH-1:0] w_nextShift;
  logic             w_nextSout;
  logic             w_nextValid;
  logic             w_nextDone;
  logic             w_lastData;
  logic             w_readyState;
  logic             w_accept;
  logic             w_firstBit;
  logic             w_headBit;
  logic [WIDTH-1:0] w_loadShift;
  logic [WIDTH-1:0] w_advShift;

`ifdef PISO_PARITY_EN
  logic r_parity;
  logic w_nextParity;
`endif

  // The shift register holds the not-yet-sent bits with the next one at the head.
  assign w_firstBit  = MSB_FIRST ? x[WIDTH-1] : x[0];
  assign w_headBit   = MSB_FIRST ? r_shift[WIDTH-1] : r_shift[0];
  assign w_loadShift = MSB_FIRST ? (x << 1) : (x >> 1);
  assign w_advShift  = MSB_FIRST ? (r_shift << 1) : (r_shift >> 1);

  assign w_cntInc   = r_cnt + CNT_W'(1);
  assign w_lastData = (r_state == SHIFT) && (r_cnt == LAST_CNT);

`ifdef PISO_PARITY_EN
  assign w_readyState = (r_state == IDLE) || (r_state == PARITY);
`else
  assign w_readyState = (r_state == IDLE) || w_lastData;
`endif

  assign load_ready = reset && w_readyState;
  assign w_accept   = load_valid && load_ready;

  always_comb begin
    w_nextState = r_state;
    w_nextCnt   = r_cnt;
    w_nextShift = r_shift;
    w_nextSout  = 1'b0;
    w_nextValid = 1'b0;
    w_nextDone  = 1'b0;
`ifdef PISO_PARITY_EN
    w_nextParity = r_parity;
`endif

    case (r_state)
      IDLE: begin
        w_nextCnt = '0;
      end
      SHIFT: begin
        if (!w_lastData) begin
          w_nextSout  = w_headBit;
          w_nextValid = 1'b1;
          w_nextShift = w_advShift;
          w_nextCnt   = w_cntInc;
          w_nextDone  = DONE_ON_DATA && (w_cntInc == LAST_CNT);
        end else begin
`ifdef PISO_PARITY_EN
          w_nextState = PARITY;
          w_nextSout  = r_parity;
          w_nextValid = 1'b1;
          w_nextDone  = 1'b1;
`else
          w_nextState = IDLE;
          w_nextCnt   = '0;
`endif
        end
      end
`ifdef PISO_PARITY_EN
      PARITY: begin
        w_nextState = IDLE;
        w_nextCnt   = '0;
      end
`endif
      default: begin
        w_nextState = IDLE;
        w_nextCnt   = '0;
      end
    endcase

    // Accept only happens in a ready cycle, so it overrides the drain/idle path.
    if (w_accept) begin
      w_nextState = SHIFT;
      w_nextCnt   = CNT_W'(1);
      w_nextShift = w_loadShift;
      w_nextSout  = w_firstBit;
      w_nextValid = 1'b1;
      w_nextDone  = 1'b0;
`ifdef PISO_PARITY_EN
      w_nextParity = ^x;
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_shift <= '0;
      r_sout  <= 1'b0;
      r_valid <= 1'b0;
      r_done  <= 1'b0;
`ifdef PISO_PARITY_EN
      r_parity <= 1'b0;
`endif
    end else begin
      r_state <= w_nextState;
      r_cnt   <= w_nextCnt;
      r_shift <= w_nextShift;
      r_sout  <= w_nextSout;
      r_valid <= w_nextValid;
      r_done  <= w_nextDone;
`ifdef PISO_PARITY_EN
      r_parity <= w_nextParity;
`endif
    end
  end

  assign sout       = r_sout;
  assign sout_valid = r_valid;
  assign done       = r_done;

endmodule

// File: tb/tb_piso_serializer.sv
// Directed bench for piso_serializer: an MSB-first and an LSB-first instance share stimulus.
// Builds with or without PISO_PARITY_EN; the vector table follows the build.
module tb_piso_serializer;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] x;
  logic       loadValid;

  logic readyM, soutM, validM, doneM;
  logic readyL, soutL, validL, doneL;

  int passCount  = 0;
  int checkCount = 0;

  always #5 clk = ~clk;

  piso_serializer #(.WIDTH(4), .MSB_FIRST(1'b1)) dutMsb (
    .clk(clk), .reset(reset), .x(x), .load_valid(loadValid),
    .load_ready(readyM), .sout(soutM), .sout_valid(validM), .done(doneM)
  );

  piso_serializer #(.WIDTH(4), .MSB_FIRST(1'b0)) dutLsb (
    .clk(clk), .reset(reset), .x(x), .load_valid(loadValid),
    .load_ready(readyL), .sout(soutL), .sout_valid(validL), .done(doneL)
  );

  // One row per cycle: inputs driven at the falling edge, outputs expected in that same cycle.
  typedef struct packed {
    logic       rst;
    logic [3:0] xv;
    logic       lv;
    logic       eM;
    logic       eL;
    logic       eV;
    logic       eD;
    logic       eR;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mkVec(input logic r, input logic [3:0] xv, input logic lv,
                                 input logic eM, input logic eL, input logic eV,
                                 input logic eD, input logic eR);
    vec_t v;
    v.rst = r;  v.xv = xv; v.lv = lv;
    v.eM  = eM; v.eL = eL; v.eV = eV; v.eD = eD; v.eR = eR;
    return v;
  endfunction

  task automatic checkBit(input string name, input logic actual, input logic expected);
    checkCount++;
    if (actual === expected) passCount++;
    else $display("[TB] FAIL %s: got %b, expected %b", name, actual, expected);
  endtask

  task automatic applyStimulus(input logic r, input logic [3:0] xv, input logic lv);
    @(negedge clk);
    reset     = r;
    x         = xv;
    loadValid = lv;
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic eM, input logic eL,
                             input logic eV, input logic eD, input logic eR);
    checkBit({tag, " sout_msb"},  soutM,  eM);
    checkBit({tag, " sout_lsb"},  soutL,  eL);
    checkBit({tag, " valid_msb"}, validM, eV);
    checkBit({tag, " valid_lsb"}, validL, eV);
    checkBit({tag, " done_msb"},  doneM,  eD);
    checkBit({tag, " done_lsb"},  doneL,  eD);
    checkBit({tag, " ready_msb"}, readyM, eR);
    checkBit({tag, " ready_lsb"}, readyL, eR);
  endtask

  initial begin
    reset     = 1'b0;
    x         = 4'h0;
    loadValid = 1'b0;

    // Two reset cycles: ready is forced low while reset is asserted.
    vecs.push_back(mkVec(0, 4'h0, 0, 0, 0, 0, 0, 0));
    vecs.push_back(mkVec(0, 4'h0, 0, 0, 0, 0, 0, 0));
`ifndef PISO_PARITY_EN
    // Single word 1011, then back to idle.
    vecs.push_back(mkVec(1, 4'hB, 1, 0, 0, 0, 0, 1));
    vecs.push_back(mkVec(1, 4'h0, 0, 1, 1, 1, 0, 0));
    vecs.push_back(mkVec(1, 4'h0, 0, 0, 1, 1, 0, 0));
    vecs.push_back(mkVec(1, 4'h0, 0, 1, 0, 1, 0, 0));
    vecs.push_back(mkVec(1, 4'h0, 0, 1, 1, 1, 1, 1));
    vecs.push_back(mkVec(1, 4'h0, 0, 0, 0, 0, 0, 1));
    // Back-to-back 1011 then 0110 with load_valid held.
    vecs.push_back(mkVec(1, 4'hB, 1, 0, 0, 0, 0, 1));
    vecs.push_back(mkVec(1, 4'h6, 1, 1, 1, 1, 0, 0));
    vecs.push_back(mkVec(1, 4'h6, 1, 0, 1, 1, 0, 0));
    vecs.push_back(mkVec(1, 4'h6, 1, 1, 0, 1, 0, 0));
    vecs.push_back(mkVec(1, 4'h6, 1, 1, 1, 1, 1, 1));
    vecs.push_back(mkVec(1, 4'h0, 0, 0, 0, 1, 0, 0));
    vecs.push_back(mkVec(1, 4'h0, 0, 1, 1, 1, 0, 0));
    vecs.push_back(mkVec(1, 4'h0, 0, 1, 1, 1, 0, 0));
    vecs.push_back(mkVec(1, 4'h0, 0, 0, 0, 1, 1, 1));
    vecs.push_back(mkVec(1, 4'h0, 0, 0, 0, 0, 0, 1));
    // Reset during bit 2 of 1011, then 0001.
    vecs.push_back(mkVec(1, 4'hB, 1, 0, 0, 0, 0, 1));
    vecs.push_back(mkVec(1, 4'h0, 0, 1, 1, 1, 0, 0));
    vecs.push_back(mkVec(0, 4'h0, 0, 0, 1, 1, 0, 0));
    vecs.push_back(mkVec(1, 4'h0, 0, 0, 0, 0, 0, 1));
    vecs.push_back(mkVec(1, 4'h1, 1, 0, 0, 0, 0, 1));
    vecs.push_back(mkVec(1, 4'h0, 0, 0, 1, 1, 0, 0));
    vecs.push_back(mkVec(1, 4'h0, 0, 0, 0, 1, 0, 0));
    vecs.push_back(mkVec(1, 4'h0, 0, 0, 0, 1, 0, 0));
    vecs.push_back(mkVec(1, 4'h0, 0, 1, 0, 1, 1, 1));
    vecs.push_back(mkVec(1, 4'h0, 0, 0, 0, 0, 0, 1));
    // x toggling with load_valid high while not ready: captured word must survive.
    vecs.push_back(mkVec(1, 4'hB, 1, 0, 0, 0, 0, 1));
    vecs.push_back(mkVec(1, 4'h4, 1, 1, 1, 1, 0, 0));
    vecs.push_back(mkVec(1, 4'hF, 1, 0, 1, 1, 0, 0));
    vecs.push_back(mkVec(1, 4'h0, 1, 1, 0, 1, 0, 0));
    vecs.push_back(mkVec(1, 4'hF, 0, 1, 1, 1, 1, 1));
    vecs.push_back(mkVec(1, 4'h0, 0, 0, 0, 0, 0, 1));
`else
    // 1011 with parity 1, back-to-back 0110 accepted in the parity cycle, parity 0.
    vecs.push_back(mkVec(1, 4'hB, 1, 0, 0, 0, 0, 1));
    vecs.push_back(mkVec(1, 4'h0, 0, 1, 1, 1, 0, 0));
    vecs.push_back(mkVec(1, 4'h0, 0, 0, 1, 1, 0, 0));
    vecs.push_back(mkVec(1, 4'h0, 0, 1, 0, 1, 0, 0));
    vecs.push_back(mkVec(1, 4'h0, 0, 1, 1, 1, 0, 0));
    vecs.push_back(mkVec(1, 4'h6, 1, 1, 1, 1, 1, 1));
    vecs.push_back(mkVec(1, 4'h0, 0, 0, 0, 1, 0, 0));
    vecs.push_back(mkVec(1, 4'h0, 0, 1, 1, 1, 0, 0));
    vecs.push_back(mkVec(1, 4'h0, 0, 1, 1, 1, 0, 0));
    vecs.push_back(mkVec(1, 4'h0, 0, 0, 0, 1, 0, 0));
    vecs.push_back(mkVec(1, 4'h0, 0, 0, 0, 1, 1, 1));
    vecs.push_back(mkVec(1, 4'h0, 0, 0, 0, 0, 0, 1));
`endif

    foreach (vecs[i]) begin
      applyStimulus(vecs[i].rst, vecs[i].xv, vecs[i].lv);
      checkOutput($sformatf("v%0d", i), vecs[i].eM, vecs[i].eL,
                  vecs[i].eV, vecs[i].eD, vecs[i].eR);
    end

    // A load request during reset must not be taken.
    applyStimulus(0, 4'hF, 1);
    checkOutput("rstLoad", 0, 0, 0, 0, 0);
    applyStimulus(1, 4'h0, 0);
    checkOutput("rstLoadAfter", 0, 0, 0, 0, 1);
    applyStimulus(1, 4'h0, 0);
    checkOutput("rstLoadIdle", 0, 0, 0, 0, 1);

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
